// File: rtl/mux_nto1_rr.sv
// N-to-1 stream mux with fixed-select or round-robin channel choice feeding a
// single-entry output register. Define MUX_XFER_CNT_EN to enable the xfer_cnt counter.
module mux_nto1_rr #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  se,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [SW-1:0]  grant,
  output logic [15:0]    xfer_cnt
);

  logic [W-1:0]  y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          room;
  logic          chosen;
  logic          ld;
  logic [SW-1:0] c;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [W-1:0]  sel_data;

  // The output slot can take new data when empty or being drained this cycle.
  assign room = en & ~rst & (~y_valid_q | y_ready);

  // Round-robin search starting at ptr_q, wrapping at N (N need not be a power of 2).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < N; k++) begin
      logic [SW:0] j;
      j = {1'b0, ptr_q} + (SW+1)'(k);
      if (j >= (SW+1)'(N)) j = j - (SW+1)'(N);
      if (!rr_found && in_valid[j[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = j[SW-1:0];
      end
    end
  end

  always_comb begin
    chosen = 1'b0;
    c      = '0;
    if (mode) begin
      chosen = rr_found;
      c      = rr_idx;
    end else if (int'(se) < N) begin
      chosen = 1'b1;
      c      = se;
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (c == SW'(i)) begin
        in_ready[i] = room & chosen;
        sel_data    = in_data[i*W +: W];
      end
    end
  end

  assign ld = room & chosen & in_valid[c];

  always_comb begin
    y_d       = y_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    y_valid_d = y_valid_q;
    if (ld) begin
      y_d       = sel_data;
      grant_d   = c;
      y_valid_d = 1'b1;
      if (mode) ptr_d = (c == SW'(N-1)) ? '0 : c + SW'(1);
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      grant_q   <= '0;
      ptr_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign grant   = grant_q;

`ifdef MUX_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (ld && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule
